// File: rtl/lcd_message_arbiter_if.sv
// Requester-side bundle of the LCD message arbiter: per-requester request/byte lanes
// plus the grant, handshake pulses and committed character buffer.
interface lcd_message_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] data;
    logic [NREQ-1:0]   valid;
    logic [NREQ-1:0]   grant;
    logic              ready;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   abort;
    logic [255:0]      chars;
    logic              chars_update;

    modport master (
        output req, data, valid,
        input  grant, ready, done, abort, chars, chars_update
    );

    modport slave (
        input  req, data, valid,
        output grant, ready, done, abort, chars, chars_update
    );
endinterface

// File: rtl/lcd_message_arbiter.sv
// Round-robin owner of the 32-character LCD buffer: loads a 32-byte message serially from
// the granted requester, commits it atomically, then holds it for a dwell period.
module lcd_message_arbiter #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned DWELL_CYCLES   = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input logic                 Clock,
    input logic                 Reset,
    lcd_message_arbiter_if.slave bus
);
    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StCommit, StDwell} state_e;

    state_e            state_q;
    logic [NREQ-1:0]   grant_q;
    logic [NREQ-1:0]   done_q;
    logic [NREQ-1:0]   abort_q;
    logic              ready_q;
    logic [255:0]      chars_q;
    logic [255:0]      staging_q;
    logic              chars_update_q;
    logic [IdxW-1:0]   ptr_q;
    logic [IdxW-1:0]   gidx_q;
    logic [5:0]        count_q;
    logic [31:0]       timer_q;
    logic [31:0]       dwell_q;

    logic              pick_found;
    logic [IdxW-1:0]   pick_idx;
    logic [IdxW-1:0]   next_ptr;
    logic              req_g;
    logic              valid_g;
    logic [7:0]        data_g;
    logic              abort_now;

    // First pending request at or above the pointer, wrapping around.
    always_comb begin
        int unsigned     cand;
        logic [IdxW-1:0] cand_idx;
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_idx = IdxW'(cand);
            if (!pick_found && bus.req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign next_ptr  = (gidx_q == IdxW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
    assign req_g     = bus.req[gidx_q];
    assign valid_g   = bus.valid[gidx_q];
    assign data_g    = bus.data[{gidx_q, 3'b000} +: 8];
    // A dropped request or an expired idle timer wins over a byte in the same cycle.
    assign abort_now = !req_g || (timer_q >= 32'(TIMEOUT_CYCLES));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q        <= StIdle;
            grant_q        <= '0;
            done_q         <= '0;
            abort_q        <= '0;
            ready_q        <= 1'b0;
            chars_q        <= {32{8'h20}};
            staging_q      <= '0;
            chars_update_q <= 1'b0;
            ptr_q          <= '0;
            gidx_q         <= '0;
            count_q        <= '0;
            timer_q        <= '0;
            dwell_q        <= '0;
        end else begin
            done_q         <= '0;
            abort_q        <= '0;
            chars_update_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        grant_q <= NREQ'(1) << pick_idx;
                        gidx_q  <= pick_idx;
                        ready_q <= 1'b1;
                        count_q <= '0;
                        timer_q <= '0;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (abort_now) begin
                        abort_q <= grant_q;
                        grant_q <= '0;
                        ready_q <= 1'b0;
                        ptr_q   <= next_ptr;
                        state_q <= StIdle;
                    end else if (valid_g) begin
                        // Byte n lands at staging[255-8n -: 8], i.e. slot (31-n).
                        staging_q[{~count_q[4:0], 3'b000} +: 8] <= data_g;
                        count_q <= count_q + 6'd1;
                        timer_q <= '0;
                        if (count_q == 6'd31) begin
                            ready_q <= 1'b0;
                            state_q <= StCommit;
                        end
                    end else begin
                        timer_q <= timer_q + 32'd1;
                    end
                end
                StCommit: begin
                    chars_q        <= staging_q;
                    chars_update_q <= 1'b1;
                    done_q         <= grant_q;
                    grant_q        <= '0;
                    ptr_q          <= next_ptr;
                    dwell_q        <= '0;
                    state_q        <= (DWELL_CYCLES == 0) ? StIdle : StDwell;
                end
                StDwell: begin
                    if (dwell_q + 32'd1 >= 32'(DWELL_CYCLES)) state_q <= StIdle;
                    else                                      dwell_q <= dwell_q + 32'd1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.grant        = grant_q;
    assign bus.ready        = ready_q;
    assign bus.done         = done_q;
    assign bus.abort        = abort_q;
    assign bus.chars        = chars_q;
    assign bus.chars_update = chars_update_q;
endmodule

// File: tb/tb_lcd_message_arbiter.sv
// Directed bench for lcd_message_arbiter: reset, single message, drop, timeout,
// round-robin with dwell, and reset in the middle of a load.
module tb_lcd_message_arbiter;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned DWELL = 10;
    localparam int unsigned TMO   = 5;
    localparam logic [255:0] SPACES = {32{8'h20}};

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    lcd_message_arbiter_if #(.NREQ(NREQ)) bus ();

    lcd_message_arbiter #(
        .NREQ          (NREQ),
        .DWELL_CYCLES  (DWELL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [255:0] hello;

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic pulse_reset;
        Reset = 1'b1;
        bus.req = '0;
        bus.valid = '0;
        tick();
        Reset = 1'b0;
    endtask

    function automatic logic [7:0] lane_byte(input int r, input int n);
        return 8'(8'h30 + r * 16 + n);
    endfunction

    function automatic logic [255:0] rr_msg(input int r);
        logic [255:0] m;
        for (int n = 0; n < 32; n++) m[255 - 8 * n -: 8] = lane_byte(r, n);
        return m;
    endfunction

    task automatic drive_lanes(input int n);
        for (int r = 0; r < int'(NREQ); r++) bus.data[r * 8 +: 8] = lane_byte(r, n);
    endtask

    task automatic wait_grant(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (bus.grant == '0 && cycles < 40);
    endtask

    task automatic test_reset;
        bus.req = '0; bus.valid = '0; bus.data = '0;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        vectors++;
        if (bus.chars !== SPACES) begin
            miscompares++;
            $display("FAIL reset_chars: got %h expected %h", bus.chars, SPACES);
        end
        vectors++;
        if (bus.grant !== 4'b0 || bus.done !== 4'b0 || bus.abort !== 4'b0 ||
            bus.chars_update !== 1'b0 || bus.ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: grant=%b done=%b abort=%b upd=%b ready=%b expected all 0",
                     bus.grant, bus.done, bus.abort, bus.chars_update, bus.ready);
        end
    endtask

    task automatic test_single;
        bus.req = 4'b0001;
        vectors++;
        if (bus.grant !== 4'b0) begin
            miscompares++;
            $display("FAIL single_grant_early: got %b expected 0000", bus.grant);
        end
        tick();
        vectors++;
        if (bus.grant !== 4'b0001 || bus.ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_grant: got grant=%b ready=%b expected 0001/1", bus.grant, bus.ready);
        end
        for (int n = 0; n < 32; n++) begin
            bus.data = '0;
            bus.data[7:0] = hello[255 - 8 * n -: 8];
            bus.data[15:8] = 8'hFF;
            bus.valid = 4'b0011;
            tick();
        end
        bus.valid = '0;
        vectors++;
        if (bus.ready !== 1'b0 || bus.done !== 4'b0 || bus.chars !== SPACES) begin
            miscompares++;
            $display("FAIL single_precommit: ready=%b done=%b chars=%h expected 0/0000/spaces",
                     bus.ready, bus.done, bus.chars);
        end
        tick();
        vectors++;
        if (bus.done !== 4'b0001 || bus.chars_update !== 1'b1 || bus.grant !== 4'b0) begin
            miscompares++;
            $display("FAIL single_done: done=%b upd=%b grant=%b expected 0001/1/0000",
                     bus.done, bus.chars_update, bus.grant);
        end
        vectors++;
        if (bus.chars !== hello || bus.chars[255:248] !== 8'h48) begin
            miscompares++;
            $display("FAIL single_chars: got %h expected %h", bus.chars, hello);
        end
        bus.req = '0;
        tick();
        vectors++;
        if (bus.done !== 4'b0 || bus.chars_update !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pulse_width: done=%b upd=%b expected 0000/0", bus.done,
                     bus.chars_update);
        end
        repeat (11) tick();
    endtask

    task automatic test_drop;
        int c;
        bus.req = 4'b0001;
        wait_grant(c);
        vectors++;
        if (bus.grant !== 4'b0001 || c != 1) begin
            miscompares++;
            $display("FAIL drop_grant: grant=%b after %0d cycles expected 0001 after 1",
                     bus.grant, c);
        end
        for (int n = 0; n < 11; n++) begin
            bus.data[7:0] = 8'(8'hA0 + n);
            bus.valid = 4'b0001;
            tick();
        end
        bus.req = '0;
        bus.data[7:0] = 8'hAB;
        tick();
        vectors++;
        if (bus.abort !== 4'b0001 || bus.done !== 4'b0 || bus.chars_update !== 1'b0 ||
            bus.grant !== 4'b0 || bus.ready !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_abort: abort=%b done=%b upd=%b grant=%b ready=%b expected 0001/0/0/0/0",
                     bus.abort, bus.done, bus.chars_update, bus.grant, bus.ready);
        end
        vectors++;
        if (bus.chars !== hello) begin
            miscompares++;
            $display("FAIL drop_chars_kept: got %h expected %h", bus.chars, hello);
        end
        bus.valid = '0;
        tick();
        vectors++;
        if (bus.abort !== 4'b0) begin
            miscompares++;
            $display("FAIL drop_abort_pulse: got %b expected 0000", bus.abort);
        end
    endtask

    task automatic test_timeout;
        logic early;
        pulse_reset();
        bus.req = 4'b0110;
        tick();
        vectors++;
        if (bus.grant !== 4'b0010) begin
            miscompares++;
            $display("FAIL timeout_grant: got %b expected 0010", bus.grant);
        end
        for (int n = 0; n < 4; n++) begin
            drive_lanes(n);
            bus.valid = 4'b0010;
            tick();
        end
        bus.valid = '0;
        early = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.abort !== 4'b0) early = 1'b1;
        end
        vectors++;
        if (early) begin
            miscompares++;
            $display("FAIL timeout_early: abort seen within 5 idle cycles, expected none");
        end
        tick();
        vectors++;
        if (bus.abort !== 4'b0010 || bus.grant !== 4'b0 || bus.chars_update !== 1'b0 ||
            bus.chars !== SPACES) begin
            miscompares++;
            $display("FAIL timeout_abort: abort=%b grant=%b upd=%b chars=%h expected 0010/0/0/spaces",
                     bus.abort, bus.grant, bus.chars_update, bus.chars);
        end
        bus.req = 4'b0100;
        tick();
        vectors++;
        if (bus.grant !== 4'b0100 || bus.abort !== 4'b0) begin
            miscompares++;
            $display("FAIL timeout_next_grant: grant=%b abort=%b expected 0100/0000", bus.grant,
                     bus.abort);
        end
        for (int n = 0; n < 2; n++) begin
            drive_lanes(n);
            bus.valid = 4'b0100;
            tick();
        end
        bus.valid = '0;
        repeat (5) tick();
        drive_lanes(2);
        bus.valid = 4'b0100;
        tick();
        vectors++;
        if (bus.abort !== 4'b0100 || bus.done !== 4'b0) begin
            miscompares++;
            $display("FAIL timeout_priority: abort=%b done=%b expected 0100/0000", bus.abort,
                     bus.done);
        end
        bus.req = '0;
        bus.valid = '0;
    endtask

    task automatic test_round_robin;
        int c;
        int exp_c;
        logic [3:0] exp_g;
        pulse_reset();
        bus.req = 4'b1111;
        bus.valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(c);
            exp_c = (k == 0) ? 1 : 11;
            exp_g = 4'b0001 << (k % 4);
            vectors++;
            if (bus.grant !== exp_g || c != exp_c) begin
                miscompares++;
                $display("FAIL rr_grant%0d: grant=%b after %0d cycles expected %b after %0d",
                         k, bus.grant, c, exp_g, exp_c);
            end
            if (k == 4) begin
                bus.req = '0;
                bus.valid = '0;
                tick();
                vectors++;
                if (bus.abort !== 4'b0001) begin
                    miscompares++;
                    $display("FAIL rr_drop: abort=%b expected 0001", bus.abort);
                end
            end else begin
                for (int n = 0; n < 32; n++) begin
                    drive_lanes(n);
                    tick();
                end
                tick();
                vectors++;
                if (bus.done !== exp_g || bus.chars_update !== 1'b1 || bus.chars !== rr_msg(k)) begin
                    miscompares++;
                    $display("FAIL rr_commit%0d: done=%b upd=%b chars=%h expected %b/1/%h",
                             k, bus.done, bus.chars_update, bus.chars, exp_g, rr_msg(k));
                end
            end
        end
    endtask

    task automatic test_reset_mid_load;
        int c;
        logic saw_done;
        bus.req = 4'b0100;
        wait_grant(c);
        vectors++;
        if (bus.grant !== 4'b0100) begin
            miscompares++;
            $display("FAIL midrst_grant: got %b expected 0100", bus.grant);
        end
        for (int n = 0; n < 21; n++) begin
            drive_lanes(n);
            bus.valid = 4'b0100;
            tick();
        end
        Reset = 1'b1;
        bus.req = '0;
        bus.valid = '0;
        tick();
        Reset = 1'b0;
        vectors++;
        if (bus.grant !== 4'b0 || bus.ready !== 1'b0 || bus.chars !== SPACES ||
            bus.done !== 4'b0 || bus.chars_update !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_state: grant=%b ready=%b done=%b upd=%b chars=%h expected 0/0/0/0/spaces",
                     bus.grant, bus.ready, bus.done, bus.chars_update, bus.chars);
        end
        saw_done = 1'b0;
        repeat (3) begin
            tick();
            if (bus.done !== 4'b0) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done) begin
            miscompares++;
            $display("FAIL midrst_no_done: done pulse seen after reset, expected none");
        end
        bus.req = 4'b1001;
        tick();
        vectors++;
        if (bus.grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL midrst_pointer: grant=%b expected 0001", bus.grant);
        end
        bus.req = '0;
    endtask

    initial begin
        hello = "HELLO, LCD ARBITER TEST MESSAGE!";
        test_reset();
        test_single();
        test_drop();
        test_timeout();
        test_round_robin();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
